// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage over a byte-wide instruction memory.
//
// Each 32-bit instruction is read one byte per cycle from a memory whose
// read data appears one cycle after its address. A small FSM walks the four
// byte addresses, assembles the word little-endian and hands it to decode
// through a single registered output slot (is/pc/vld). If decode is stalled
// when the word completes, the FSM parks in RDY until the slot frees up.
// A taken branch/jump redirects the fetch address and drops any partial word.
//
// Ports
//   clk       in   1   clock, all state changes on the rising edge
//   rst       in   1   synchronous active-high reset
//   stall     in   1   decode cannot accept the presented instruction
//   br_e      in   1   redirect request (taken jump/branch)
//   br_pc     in  32   redirect target; low two bits are ignored
//   mem_a     out 32   byte address to instruction memory (combinational)
//   mem_dout  in   8   memory read byte for the previous cycle's mem_a
//   pc        out 32   fetch address + 4 of the presented instruction
//   is        out 32   presented instruction, 0 is a bubble
//   vld       out  1   is/pc hold a real instruction
// ---------------------------------------------------------------------------
module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_e,
    input  logic [31:0] br_pc,
    output logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    output logic [31:0] pc,
    output logic [31:0] is,
    output logic        vld
);

    // F0..F3 put the four byte addresses out; F4 sees the last byte on
    // mem_dout; RDY holds a complete word while decode is stalled.
    typedef enum logic [2:0] {
        F0  = 3'd0,
        F1  = 3'd1,
        F2  = 3'd2,
        F3  = 3'd3,
        F4  = 3'd4,
        RDY = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] fpc;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;

    logic        slot_free;
    logic        load;
    logic [7:0]  top_byte;
    logic [31:0] fpc_next;

    // Only word-aligned redirect targets are fetched.
    logic        unused_br_lo;
    assign unused_br_lo = ^br_pc[1:0];

    function automatic logic [31:0] assemble(input logic [7:0] hi,
                                             input logic [7:0] m2,
                                             input logic [7:0] m1,
                                             input logic [7:0] lo);
        return {hi, m2, m1, lo};
    endfunction

    // Modulo-2^32 by construction of the 32-bit add.
    assign fpc_next = fpc + 32'd4;

    // The output slot frees when nothing valid is shown or decode takes it.
    assign slot_free = !vld || !stall;
    assign load      = ((state == F4) || (state == RDY)) && slot_free;

    // In F4 the last byte has not been registered yet, so take it straight
    // from the memory; in RDY it was parked in b3.
    assign top_byte  = (state == F4) ? mem_dout : b3;

    always_comb begin
        mem_a = fpc;
        case (state)
            F0:      mem_a = fpc;
            F1:      mem_a = fpc + 32'd1;
            F2:      mem_a = fpc + 32'd2;
            default: mem_a = fpc + 32'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= F0;
            fpc   <= 32'd0;
            b0    <= 8'd0;
            b1    <= 8'd0;
            b2    <= 8'd0;
            b3    <= 8'd0;
            is    <= 32'd0;
            pc    <= 32'd0;
            vld   <= 1'b0;
        end else if (br_e) begin
            // Redirect wins over stall and over a pending load; the bytes
            // gathered so far are simply overwritten by the next fetch.
            state <= F0;
            fpc   <= {br_pc[31:2], 2'b00};
            is    <= 32'd0;
            vld   <= 1'b0;
        end else begin
            case (state)
                F0: state <= F1;
                F1: begin
                    b0    <= mem_dout;
                    state <= F2;
                end
                F2: begin
                    b1    <= mem_dout;
                    state <= F3;
                end
                F3: begin
                    b2    <= mem_dout;
                    state <= F4;
                end
                F4: begin
                    b3    <= mem_dout;
                    state <= load ? F0 : RDY;
                end
                RDY: state <= load ? F0 : RDY;
                default: state <= F0;
            endcase

            if (load) begin
                is  <= assemble(top_byte, b2, b1, b0);
                pc  <= fpc_next;
                vld <= 1'b1;
                fpc <= fpc_next;
            end else if (vld && !stall) begin
                // Decode consumed the word and nothing new is ready: bubble.
                is  <= 32'd0;
                vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_e;
    logic [31:0] br_pc;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic [31:0] pc;
    logic [31:0] is;
    logic        vld;

    if_stage dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .br_e     (br_e),
        .br_pc    (br_pc),
        .mem_a    (mem_a),
        .mem_dout (mem_dout),
        .pc       (pc),
        .is       (is),
        .vld      (vld)
    );

    always #5 clk = ~clk;

    int cyc  = 0;
    int base = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory, read data registered one cycle after the address.
    logic [7:0] mem [0:511];
    always @(posedge clk) mem_dout <= mem[mem_a[8:0]];

    typedef struct {
        int          cyc;
        logic [31:0] ins;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    logic prev_hold = 1'b0;

    task automatic push(input int k, input logic [31:0] ins, input logic [31:0] p);
        exp_t e;
        e.cyc = base + k;
        e.ins = ins;
        e.pc  = p;
        q.push_back(e);
    endtask

    // Monitor: a new presentation is vld high when the previous cycle was
    // not a stalled hold of the same word.
    always @(negedge clk) begin : mon
        exp_t e;
        if (vld === 1'b1 && !prev_hold) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL present: unexpected is=%h pc=%h at cycle %0d", is, pc, cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.ins !== is || e.pc !== pc) begin
                    bad++;
                    $display("FAIL present: got cycle=%0d is=%h pc=%h, want cycle=%0d is=%h pc=%h",
                             cyc, is, pc, e.cyc, e.ins, e.pc);
                end
            end
        end
        prev_hold = (vld === 1'b1) && (stall === 1'b1) && (br_e === 1'b0) && (rst === 1'b0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    // Move to the start of relative cycle k (just after its opening edge).
    task automatic at(input int k);
        while (cyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input int k);
        at(k);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        stall = 1'b0;
        br_e  = 1'b0;
        br_pc = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst  = 1'b0;
        base = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
        {mem[3], mem[2], mem[1], mem[0]}                 = 32'h0050_0093;
        {mem[7], mem[6], mem[5], mem[4]}                 = 32'h00A0_0113;
        {mem[9'h43], mem[9'h42], mem[9'h41], mem[9'h40]} = 32'h00C0_00EF;
        {mem[9'h103], mem[9'h102], mem[9'h101], mem[9'h100]} = 32'h0001_0537;
        {mem[9'h1FF], mem[9'h1FE], mem[9'h1FD], mem[9'h1FC]} = 32'h0000_006F;

        // Basic and back-to-back fetch.
        do_reset();
        push(5,  32'h0050_0093, 32'h4);
        push(10, 32'h00A0_0113, 32'h8);
        sample(0);
        chk("reset vld", {31'd0, vld}, 32'd0);
        chk("reset is", is, 32'd0);
        chk("reset pc", pc, 32'd0);
        chk("mem_a c0", mem_a, 32'd0);
        sample(1); chk("mem_a c1", mem_a, 32'd1);
        sample(2); chk("mem_a c2", mem_a, 32'd2);
        sample(3); chk("mem_a c3", mem_a, 32'd3);
        sample(4); chk("mem_a F4", mem_a, 32'd3);
        sample(5); chk("mem_a c5", mem_a, 32'd4);
        sample(6);
        chk("bubble vld", {31'd0, vld}, 32'd0);
        chk("bubble is", is, 32'd0);
        chk("bubble pc", pc, 32'h4);
        sample(11);

        // Stall hold: decode stalled over cycles 5..11, released in 12.
        do_reset();
        push(5,  32'h0050_0093, 32'h4);
        push(13, 32'h00A0_0113, 32'h8);
        at(5); stall = 1'b1;
        sample(8);
        chk("hold is c8", is, 32'h0050_0093);
        chk("hold pc c8", pc, 32'h4);
        sample(11);
        chk("RDY mem_a", mem_a, 32'h7);
        at(12); stall = 1'b0;
        @(negedge clk);
        chk("hold is c12", is, 32'h0050_0093);
        chk("hold vld c12", {31'd0, vld}, 32'd1);
        sample(14);
        chk("after stall bubble", {31'd0, vld}, 32'd0);

        // Redirect mid-fetch to an unaligned target.
        do_reset();
        push(5,  32'h0050_0093, 32'h4);
        push(13, 32'h0001_0537, 32'h104);
        at(7); br_e = 1'b1; br_pc = 32'h103;
        at(8); br_e = 1'b0;
        @(negedge clk);
        chk("redir vld", {31'd0, vld}, 32'd0);
        chk("redir is", is, 32'd0);
        chk("redir mem_a", mem_a, 32'h100);
        sample(14);

        // Redirect while a stalled word is being presented.
        do_reset();
        push(5,  32'h0050_0093, 32'h4);
        push(11, 32'h00C0_00EF, 32'h44);
        at(5); stall = 1'b1; br_e = 1'b1; br_pc = 32'h40;
        at(6); stall = 1'b0; br_e = 1'b0;
        @(negedge clk);
        chk("redir+stall vld", {31'd0, vld}, 32'd0);
        chk("redir+stall is", is, 32'd0);
        chk("redir+stall mem_a", mem_a, 32'h40);
        sample(12);

        // Redirect in F4 beats the load that would otherwise happen.
        do_reset();
        push(10, 32'h00C0_00EF, 32'h44);
        at(4); br_e = 1'b1; br_pc = 32'h40;
        at(5); br_e = 1'b0;
        @(negedge clk);
        chk("F4 redir vld", {31'd0, vld}, 32'd0);
        chk("F4 redir mem_a", mem_a, 32'h40);
        sample(11);

        // Address wrap at the top of the address space.
        do_reset();
        push(6,  32'h0000_006F, 32'h0);
        push(11, 32'h0050_0093, 32'h4);
        at(0); br_e = 1'b1; br_pc = 32'hFFFF_FFFF;
        at(1); br_e = 1'b0;
        @(negedge clk);
        chk("wrap mem_a F0", mem_a, 32'hFFFF_FFFC);
        sample(4);
        chk("wrap mem_a F3", mem_a, 32'hFFFF_FFFF);
        sample(12);

        // Reset mid-fetch at fpc=0x20, asserted together with a redirect.
        do_reset();
        push(5, 32'h0050_0093, 32'h4);
        at(5); br_e = 1'b1; br_pc = 32'h20;
        at(6); br_e = 1'b0;
        at(8); rst = 1'b1; br_e = 1'b1; br_pc = 32'h80;
        @(negedge clk);
        chk("pre-rst mem_a F2", mem_a, 32'h22);
        chk("pre-rst pc", pc, 32'h4);
        at(9); rst = 1'b0; br_e = 1'b0;
        base = cyc;
        push(5, 32'h0050_0093, 32'h4);
        @(negedge clk);
        chk("rst vld", {31'd0, vld}, 32'd0);
        chk("rst pc", pc, 32'd0);
        chk("rst is", is, 32'd0);
        chk("rst mem_a", mem_a, 32'd0);
        sample(6);

        chk("queue drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 The module SHALL have port stall, input, 1: high when the decode stage cannot accept the presented instruction.
REQ-004 The module SHALL have port br_e, input, 1: redirect request from a taken jump or branch.
REQ-005 The module SHALL have port br_pc, input, 32: redirect target address.
REQ-006 The module SHALL have port mem_a, output, 32: byte address to instruction memory.
REQ-007 The module SHALL have port mem_dout, input, 8: memory read byte, valid one cycle after its address is on mem_a.
REQ-008 The module SHALL have port pc, output, 32, registered: fetch address + 4 of the presented instruction, as decode expects.
REQ-009 The module SHALL have port is, output, 32, registered: presented instruction; 0 means bubble.
REQ-010 The module SHALL have port vld, output, 1, registered: is/pc hold a real instruction.

Function
REQ-011 The module SHALL keep an internal fetch address fpc (32 bit) and an FSM with states F0, F1, F2, F3, F4 and RDY.
REQ-012 The module SHALL drive mem_a combinationally as fpc+0 in F0, fpc+1 in F1, fpc+2 in F2, fpc+3 in F3, and fpc+3 in F4 and RDY.
REQ-013 The FSM SHALL step F0->F1->F2->F3->F4 unconditionally, one state per cycle.
REQ-014 The module SHALL capture mem_dout into byte register b0 in F1, b1 in F2, b2 in F3, and b3 in F4.
REQ-015 The module SHALL assemble the instruction little-endian: {b3,b2,b1,b0}; in F4 the byte b3 is taken directly from mem_dout.
REQ-016 The output slot SHALL count as free at an edge when vld==0 or stall==0.
REQ-017 In F4 with the slot free, the module SHALL load is={mem_dout,b2,b1,b0}, pc=fpc+4 and vld=1, set fpc<=fpc+4, and go to F0.
REQ-018 In F4 with the slot not free, the module SHALL go to RDY with b3 stored.
REQ-019 In RDY, the module SHALL wait until the slot is free, then perform the same load from {b3,b2,b1,b0}, set fpc+=4 and go to F0.
REQ-020 When vld==1 and stall==1, is, pc and vld SHALL hold unchanged.
REQ-021 When vld==1, stall==0 and no load occurs at that edge, the module SHALL clear vld to 0 and is to 0 (bubble) and hold pc.
REQ-022 When not stalled, the fetch latency SHALL be 5 cycles from entering F0 to vld high, and throughput SHALL be one instruction per 5 cycles.
REQ-023 On br_e==1 at an edge, in any state, the module SHALL set fpc<={br_pc[31:2],2'b00}, set state to F0, and clear vld and is to 0.
REQ-024 On br_e==1, any partially assembled instruction SHALL be discarded.
REQ-025 br_e SHALL take priority over stall and over an F4/RDY load at the same edge.
REQ-026 fpc and pc arithmetic SHALL be modulo 2^32; fpc=0xFFFFFFFC wraps to 0.

Reset
REQ-027 When rst==1 at an edge, the module SHALL set fpc=0, state=F0, b0..b3=0, is=0, pc=0 and vld=0; mem_a therefore reads 0.
REQ-028 rst SHALL override br_e and stall.
REQ-029 rst asserted mid-fetch SHALL abandon that fetch.
REQ-030 The first fetch after rst deasserts SHALL start at address 0.

Verification
REQ-031 The bench SHALL cover basic fetch: memory bytes 0..3 = 93 00 50 00, release rst, stall=0 -> mem_a 0,1,2,3 on cycles 0-3; cycle 5: vld=1, is=0x00500093, pc=0x4; cycle 5: mem_a=4.
REQ-032 The bench SHALL cover back-to-back fetch: bytes 4..7 = 13 01 A0 00 -> cycle 6 vld=0, is=0; cycle 10 vld=1, is=0x00A00113, pc=0x8.
REQ-033 The bench SHALL cover stall hold: stall=1 from cycle 5 to cycle 12 -> is=0x00500093 held through cycle 12; FSM waits in RDY; next instruction presented at cycle 13, pc=0x8.
REQ-034 The bench SHALL cover redirect: br_e=1, br_pc=0x103 in cycle 7 -> cycle 8: vld=0, is=0, mem_a=0x100; instruction from bytes 0x100..0x103 presented at cycle 13 with pc=0x104.
REQ-035 The bench SHALL cover redirect with stall: br_e=1 and stall=1 while vld=1 -> vld=0 next cycle, and the refetch starts at br_pc.
REQ-036 The bench SHALL cover reset mid-fetch: rst=1 in state F2 at fpc=0x20 -> next cycle vld=0, pc=0, is=0, mem_a=0; fetch restarts at address 0.
